// File: rtl/sine_phase_sequencer.sv
// sine_phase_sequencer
// Front/back-end sequencer for an iterative CORDIC sine/cosine core. It folds a
// full-circle phase into the core's +/-90 deg range, converts it to Q8.8 degrees,
// starts the core, waits for done under a watchdog, applies the quadrant sign
// correction and hands the result downstream.
//
// Ports:
//   Clk_i, Rst_i                      clock, synchronous active-high reset
//   Phase_i, Valid_i, Ready_o         phase input handshake (65536 counts = 360 deg)
//   Sin_o, Cos_o, Err_o, Valid_o,
//   Ready_i                           Q1.15 result handshake, Err_o = watchdog timeout
//   Core_Angle_o, Core_Start_o        Q8.8 degree angle and start pulse to the core
//   Core_Done_i, Core_Sine_i,
//   Core_Cos_i                        core completion and results
//
// Configuration macro: SINE_NEG_SAT_EN -- when defined, negating 16'h8000
// saturates to 16'h7FFF instead of wrapping.
module sine_phase_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES   = 40,
    parameter int unsigned DONE_MASK_CYCLES = 2
) (
    input  logic        Clk_i,
    input  logic        Rst_i,
    input  logic [15:0] Phase_i,
    input  logic        Valid_i,
    output logic        Ready_o,
    output logic [15:0] Sin_o,
    output logic [15:0] Cos_o,
    output logic        Valid_o,
    input  logic        Ready_i,
    output logic        Err_o,
    output logic [15:0] Core_Angle_o,
    output logic        Core_Start_o,
    input  logic        Core_Done_i,
    input  logic [15:0] Core_Sine_i,
    input  logic [15:0] Core_Cos_i
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROD_W = 23;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [PROD_W-1:0] ANGLE_SCALE = 23'sd45;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [DATA_W-1:0]  angle_q, angle_d;
    logic [DATA_W-1:0]  sin_q, sin_d;
    logic [DATA_W-1:0]  cos_q, cos_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;

    logic                     fold_neg_c;
    logic signed [DATA_W-1:0] fold_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [DATA_W-1:0]        angle_c;
    logic                     done_ok_c;
    logic                     timeout_c;

    // Two's-complement negate; optionally saturate the single unrepresentable case.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
`ifdef SINE_NEG_SAT_EN
        if (v == 16'h8000) begin
            negate = 16'h7FFF;
        end else begin
            negate = -v;
        end
`else
        negate = -v;
`endif
    endfunction

    // Quadrants 1 and 2 are rotated by 180 deg into [-90,+90) and negated afterwards.
    assign fold_neg_c = Phase_i[15] ^ Phase_i[14];
    assign fold_c     = fold_neg_c ? (Phase_i ^ 16'h8000) : Phase_i;

    // 65536 counts = 360 deg, so Q8.8 degrees = p * 360 * 256 / 65536 = p * 45 / 32.
    assign prod_c  = PROD_W'(fold_c) * ANGLE_SCALE;
    assign angle_c = DATA_W'(prod_c >>> 5);

    // cnt_q counts completed WAIT cycles; done is honoured once the mask has elapsed.
    assign done_ok_c = Core_Done_i && (cnt_q >= CNT_W'(DONE_MASK_CYCLES));
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign Ready_o      = (state_q == ST_IDLE);
    assign Sin_o        = sin_q;
    assign Cos_o        = cos_q;
    assign Err_o        = err_q;
    assign Valid_o      = valid_q;
    assign Core_Angle_o = angle_q;
    assign Core_Start_o = start_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        angle_d = angle_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        err_d   = err_q;
        valid_d = valid_q;
        start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Valid_i) begin
                    neg_d   = fold_neg_c;
                    angle_d = angle_c;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done takes priority over a coincident timeout.
                if (done_ok_c) begin
                    sin_d   = neg_q ? negate(Core_Sine_i) : Core_Sine_i;
                    cos_d   = neg_q ? negate(Core_Cos_i) : Core_Cos_i;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end else if (timeout_c) begin
                    sin_d   = '0;
                    cos_d   = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (Ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            angle_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            angle_q <= angle_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Self-checking bench for sine_phase_sequencer: directed corner cases plus
// randomized operations against a behavioural model of phase folding, angle
// scaling, sign correction and done/timeout timing.
module tb_sine_phase_sequencer;

    localparam int TO   = 40;
    localparam int MASK = 2;

    logic        Clk_i = 1'b0;
    logic        Rst_i;
    logic [15:0] Phase_i;
    logic        Valid_i;
    logic        Ready_o;
    logic [15:0] Sin_o;
    logic [15:0] Cos_o;
    logic        Valid_o;
    logic        Ready_i;
    logic        Err_o;
    logic [15:0] Core_Angle_o;
    logic        Core_Start_o;
    logic        Core_Done_i;
    logic [15:0] Core_Sine_i;
    logic [15:0] Core_Cos_i;

    int checks   = 0;
    int failures = 0;

    sine_phase_sequencer #(
        .TIMEOUT_CYCLES  (TO),
        .DONE_MASK_CYCLES(MASK)
    ) dut (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .Phase_i     (Phase_i),
        .Valid_i     (Valid_i),
        .Ready_o     (Ready_o),
        .Sin_o       (Sin_o),
        .Cos_o       (Cos_o),
        .Valid_o     (Valid_o),
        .Ready_i     (Ready_i),
        .Err_o       (Err_o),
        .Core_Angle_o(Core_Angle_o),
        .Core_Start_o(Core_Start_o),
        .Core_Done_i (Core_Done_i),
        .Core_Sine_i (Core_Sine_i),
        .Core_Cos_i  (Core_Cos_i)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Degrees in Q8.8 from the phase: fold into [-16384,16383] counts, then
    // floor(counts * 360 * 256 / 65536).
    function automatic int model_angle(input logic [15:0] ph, output bit neg);
        int p;
        int num;
        p   = int'(ph);
        neg = 1'b0;
        if (p >= 49152) p = p - 65536;
        if (p >= 16384) begin
            p   = p - 32768;
            neg = 1'b1;
        end
        num = p * 45;
        if (num >= 0) return num / 32;
        return -((-num + 31) / 32);
    endfunction

    function automatic logic [15:0] model_neg(input logic [15:0] v, input bit neg);
        int s;
        s = int'($signed(v));
        if (!neg) return v;
        if (s == -32768) begin
`ifdef SINE_NEG_SAT_EN
            return 16'h7FFF;
`else
            return 16'h8000;
`endif
        end
        return 16'(-s);
    endfunction

    // One operation. d = first edge after the accept edge at which Core_Done_i
    // is high (held from then on), -1 = never. bp = cycles of output backpressure.
    // Entry: just after a rising edge.
    task automatic run_op(input logic [15:0] ph, input logic [15:0] cs,
                          input logic [15:0] cc, input int d, input int bp);
        bit          neg;
        int          ang;
        int          eff;
        int          rise;
        bit          is_to;
        logic [15:0] exp_sin;
        logic [15:0] exp_cos;
        logic [15:0] exp_ang;

        ang     = model_angle(ph, neg);
        exp_ang = 16'(ang);
        eff     = (d < 0) ? 1000 : ((d > 2 + MASK) ? d : 2 + MASK);
        if (eff <= 1 + TO) begin
            rise  = eff;
            is_to = 1'b0;
        end else begin
            rise  = 1 + TO;
            is_to = 1'b1;
        end
        exp_sin = is_to ? 16'h0000 : model_neg(cs, neg);
        exp_cos = is_to ? 16'h0000 : model_neg(cc, neg);

        @(negedge Clk_i);
        chk("idle_ready", 16'(Ready_o), 16'h0001);
        Phase_i     = ph;
        Valid_i     = 1'b1;
        Core_Sine_i = cs;
        Core_Cos_i  = cc;
        Core_Done_i = (d == 0);
        @(posedge Clk_i);
        #1;
        for (int k = 1; k <= rise; k++) begin
            // Busy-time requests carry junk phases that must be ignored.
            Valid_i     = 1'($urandom_range(0, 1));
            Phase_i     = 16'($urandom);
            Core_Done_i = (d >= 0) && (k >= d);
            @(negedge Clk_i);
            chk("start", 16'(Core_Start_o), 16'(k == 1));
            chk("angle", Core_Angle_o, exp_ang);
            chk("busy_ready", 16'(Ready_o), 16'h0000);
            chk("valid_early", 16'(Valid_o), 16'h0000);
            @(posedge Clk_i);
            #1;
        end
        Core_Done_i = 1'b0;
        Core_Sine_i = 16'($urandom);
        Core_Cos_i  = 16'($urandom);
        @(negedge Clk_i);
        chk("valid_rise", 16'(Valid_o), 16'h0001);
        chk("sin", Sin_o, exp_sin);
        chk("cos", Cos_o, exp_cos);
        chk("err", 16'(Err_o), 16'(is_to));
        chk("angle_out", Core_Angle_o, exp_ang);
        Valid_i = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(posedge Clk_i);
            #1;
            Core_Done_i = 1'($urandom_range(0, 1));
            Core_Sine_i = 16'($urandom);
            @(negedge Clk_i);
            chk("hold_valid", 16'(Valid_o), 16'h0001);
            chk("hold_sin", Sin_o, exp_sin);
            chk("hold_cos", Cos_o, exp_cos);
            chk("hold_err", 16'(Err_o), 16'(is_to));
        end
        Core_Done_i = 1'b0;
        Ready_i     = 1'b1;
        @(posedge Clk_i);
        #1;
        Ready_i = 1'b0;
        @(negedge Clk_i);
        chk("post_valid", 16'(Valid_o), 16'h0000);
        chk("post_ready", 16'(Ready_o), 16'h0001);
        @(posedge Clk_i);
        #1;
    endtask

    initial begin
        Rst_i       = 1'b1;
        Phase_i     = '0;
        Valid_i     = 1'b0;
        Ready_i     = 1'b0;
        Core_Done_i = 1'b0;
        Core_Sine_i = '0;
        Core_Cos_i  = '0;
        repeat (2) @(posedge Clk_i);
        #1;
        Rst_i = 1'b0;
        @(negedge Clk_i);
        chk("rst_ready", 16'(Ready_o), 16'h0001);
        chk("rst_valid", 16'(Valid_o), 16'h0000);
        chk("rst_start", 16'(Core_Start_o), 16'h0000);
        chk("rst_err", 16'(Err_o), 16'h0000);
        chk("rst_sin", Sin_o, 16'h0000);
        chk("rst_cos", Cos_o, 16'h0000);
        chk("rst_angle", Core_Angle_o, 16'h0000);
        @(posedge Clk_i);
        #1;

        // Directed cases from the block's defining examples.
        run_op(16'h2000, 16'd23170, 16'd23170, 5, 0);
        run_op(16'h6000, 16'(-23170), 16'd23170, 4, 1);
        run_op(16'hC000, 16'h8000, 16'd1234, 6, 0);
        run_op(16'h8000, 16'd100, 16'h8000, 4, 2);
        run_op(16'h4000, 16'h8000, 16'h7FFF, 7, 0);
        run_op(16'h1234, 16'd500, 16'd600, 0, 0);          // stale done
        run_op(16'h3FFF, 16'd1, 16'd2, 3, 0);              // done just inside mask
        run_op(16'hBFFF, 16'd1, 16'd2, -1, 5);             // timeout with backpressure
        run_op(16'hE000, 16'd7, 16'd9, 1 + TO, 0);         // done and timeout coincide
        run_op(16'h7FFF, 16'd7, 16'd9, 2 + TO, 1);         // done one cycle too late

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            int d;
            d = int'($urandom_range(0, 46));
            if (d == 46) d = -1;
            run_op(16'($urandom), 16'($urandom), 16'($urandom), d,
                   int'($urandom_range(0, 3)));
        end

        // Reset in WAIT discards the operation.
        @(negedge Clk_i);
        Phase_i = 16'h2000;
        Valid_i = 1'b1;
        @(posedge Clk_i);
        #1;
        Valid_i = 1'b0;
        repeat (2) @(posedge Clk_i);
        #1;
        Rst_i = 1'b1;
        @(posedge Clk_i);
        #1;
        Rst_i = 1'b0;
        @(negedge Clk_i);
        chk("mid_rst_ready", 16'(Ready_o), 16'h0001);
        chk("mid_rst_valid", 16'(Valid_o), 16'h0000);
        chk("mid_rst_angle", Core_Angle_o, 16'h0000);
        chk("mid_rst_start", 16'(Core_Start_o), 16'h0000);
        chk("mid_rst_err", 16'(Err_o), 16'h0000);
        chk("mid_rst_sin", Sin_o, 16'h0000);
        Core_Done_i = 1'b1;
        Core_Sine_i = 16'h1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk_i);
            chk("late_done_valid", 16'(Valid_o), 16'h0000);
            chk("late_done_ready", 16'(Ready_o), 16'h0001);
        end
        Core_Done_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
